// File: rtl/pipe_pkg.sv
// Shared definitions for the ID-stage pipeline controller.
//   FWD_*      : operand-select encodings driven by the hazard unit
//   DW, CW     : default datapath and control-word widths
//   NOP_INSTR  : encoding placed in IF/ID on reset or flush
//   id_ex_t    : contents of the ID/EX pipeline latch
package pipe_pkg;

    localparam int DW = 32;
    localparam int CW = 16;
    localparam logic [DW-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_t;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [3:0]    rw;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] d;
        logic          valid;
    } id_ex_t;

endpackage

// File: rtl/fwd_mux4.sv
// W-wide 4:1 operand mux choosing between the register file and the
// EX / MEM / WB forwarding sources.
//   sel : operand select (FWD_RF / FWD_EX / FWD_MEM / FWD_WB)
//   rf, ex, mem, wb : candidate operand values
//   y   : selected operand (combinational)
module fwd_mux4
    import pipe_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] rf,
    input  logic [W-1:0] ex,
    input  logic [W-1:0] mem,
    input  logic [W-1:0] wb,
    output logic [W-1:0] y
);

    always_comb begin
        y = rf;
        case (fwd_sel_t'(sel))
            FWD_EX:  y = ex;
            FWD_MEM: y = mem;
            FWD_WB:  y = wb;
            default: y = rf;
        endcase
    end

endmodule

// File: rtl/id_stage_pipe_ctrl.sv
// ID-stage pipeline controller: owns the PC, the IF/ID latch and the ID/EX
// latch, and applies the hazard unit's forwarding, stall and bubble commands.
//   CLK, RST_N            : clock, asynchronous active-low reset
//   INSTR_IF              : instruction fetched at PC
//   BR_TAKEN, BR_TARGET   : branch resolved in ID and its target
//   HZld, IF_ID_ld        : PC / IF/ID load enables (0 = stall / hold)
//   C_Unit_MUX            : 1 = pass control word, 0 = inject bubble
//   ISA, ISB, ISD         : operand forwarding selects
//   RF_A, RF_B, RF_D      : register file read data
//   EX_RES/MEM_RES/WB_RES : forwarding sources
//   CTRL_ID, RW_ID        : control word and destination decoded in ID
//   PC                    : fetch address
//   INSTR_ID, PC_ID       : IF/ID latch contents
//   A_EX, B_EX, D_EX, CTRL_EX, RW_EX_O, VALID_EX : ID/EX latch contents
//   STALL_CNT             : saturating count of stall cycles
module id_stage_pipe_ctrl #(
    parameter int            DW        = pipe_pkg::DW,
    parameter int            CW        = pipe_pkg::CW,
    parameter logic [DW-1:0] NOP_INSTR = pipe_pkg::NOP_INSTR,
    parameter int            PC_STEP   = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [DW-1:0] INSTR_IF,
    input  logic          BR_TAKEN,
    input  logic [DW-1:0] BR_TARGET,
    input  logic          HZld,
    input  logic          IF_ID_ld,
    input  logic          C_Unit_MUX,
    input  logic [1:0]    ISA,
    input  logic [1:0]    ISB,
    input  logic [1:0]    ISD,
    input  logic [DW-1:0] RF_A,
    input  logic [DW-1:0] RF_B,
    input  logic [DW-1:0] RF_D,
    input  logic [DW-1:0] EX_RES,
    input  logic [DW-1:0] MEM_RES,
    input  logic [DW-1:0] WB_RES,
    input  logic [CW-1:0] CTRL_ID,
    input  logic [3:0]    RW_ID,
    output logic [DW-1:0] PC,
    output logic [DW-1:0] INSTR_ID,
    output logic [DW-1:0] PC_ID,
    output logic [DW-1:0] A_EX,
    output logic [DW-1:0] B_EX,
    output logic [DW-1:0] D_EX,
    output logic [CW-1:0] CTRL_EX,
    output logic [3:0]    RW_EX_O,
    output logic          VALID_EX,
    output logic [15:0]   STALL_CNT
);

    import pipe_pkg::id_ex_t;

    logic [DW-1:0] pc_q, pc_d;
    logic [DW-1:0] instr_id_q, instr_id_d;
    logic [DW-1:0] pc_id_q, pc_id_d;
    id_ex_t        id_ex_q, id_ex_d;
    logic [15:0]   stall_cnt_q, stall_cnt_d;

    logic [DW-1:0] op_a, op_b, op_d;
    logic          flush;

    fwd_mux4 #(.W(DW)) u_mux_a (
        .sel(ISA), .rf(RF_A), .ex(EX_RES), .mem(MEM_RES), .wb(WB_RES), .y(op_a)
    );
    fwd_mux4 #(.W(DW)) u_mux_b (
        .sel(ISB), .rf(RF_B), .ex(EX_RES), .mem(MEM_RES), .wb(WB_RES), .y(op_b)
    );
    fwd_mux4 #(.W(DW)) u_mux_d (
        .sel(ISD), .rf(RF_D), .ex(EX_RES), .mem(MEM_RES), .wb(WB_RES), .y(op_d)
    );

    // A taken branch only redirects when the front end is not stalled; a
    // stalled branch is simply seen again on the next cycle.
    assign flush = HZld && BR_TAKEN;

    // ---- IF stage: PC and IF/ID latch ----
    always_comb begin
        pc_d       = pc_q;
        instr_id_d = instr_id_q;
        pc_id_d    = pc_id_q;

        if (HZld) begin
            if (BR_TAKEN) pc_d = BR_TARGET;
            else          pc_d = pc_q + DW'(PC_STEP);
        end

        // Flush wins over IF_ID_ld so the wrong-path instruction never
        // reaches ID.
        if (flush) begin
            instr_id_d = NOP_INSTR;
            pc_id_d    = pc_q;
        end else if (IF_ID_ld) begin
            instr_id_d = INSTR_IF;
            pc_id_d    = pc_q;
        end
    end

    // ---- ID stage: operands and control into ID/EX ----
    always_comb begin
        id_ex_d   = '0;
        id_ex_d.a = op_a;
        id_ex_d.b = op_b;
        id_ex_d.d = op_d;
        if (C_Unit_MUX) begin
            id_ex_d.ctrl  = CTRL_ID;
            id_ex_d.rw    = RW_ID;
            id_ex_d.valid = (instr_id_q != NOP_INSTR);
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!HZld && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q        <= '0;
            instr_id_q  <= NOP_INSTR;
            pc_id_q     <= '0;
            id_ex_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            instr_id_q  <= instr_id_d;
            pc_id_q     <= pc_id_d;
            id_ex_q     <= id_ex_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign PC        = pc_q;
    assign INSTR_ID  = instr_id_q;
    assign PC_ID     = pc_id_q;
    assign A_EX      = id_ex_q.a;
    assign B_EX      = id_ex_q.b;
    assign D_EX      = id_ex_q.d;
    assign CTRL_EX   = id_ex_q.ctrl;
    assign RW_EX_O   = id_ex_q.rw;
    assign VALID_EX  = id_ex_q.valid;
    assign STALL_CNT = stall_cnt_q;

    // Holding PC while loading IF/ID is legal but never produced by the
    // hazard unit; flag it so a hazard-unit bug shows up early.
    hz_ifid_consistent: assert property (@(posedge CLK) disable iff (!RST_N)
        !(!HZld && IF_ID_ld));

endmodule
